// File: rtl/inst_mem_loader_if.sv
// Load-stream and fetch signals of the runtime-loadable instruction memory.
// master = loader/CPU side, slave = memory side.
interface inst_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              LOAD_START;
    logic              LOAD_VALID;
    logic [DATA_W-1:0] LOAD_DATA;
    logic              LOAD_LAST;
    logic              LOAD_READY;
    logic              LOAD_DONE;
    logic [CNT_W-1:0]  LOAD_COUNT;
    logic [ADDR_W-1:0] Read_address;
    logic              FETCH_REQ;
    logic [DATA_W-1:0] Instruction;
    logic              FETCH_VALID;
    logic              FETCH_FAULT;
    logic              BUSY;

    modport master (
        output LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, Read_address, FETCH_REQ,
        input  LOAD_READY, LOAD_DONE, LOAD_COUNT, Instruction, FETCH_VALID, FETCH_FAULT, BUSY
    );

    modport slave (
        input  LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, Read_address, FETCH_REQ,
        output LOAD_READY, LOAD_DONE, LOAD_COUNT, Instruction, FETCH_VALID, FETCH_FAULT, BUSY
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Runtime-loadable instruction memory (IDLE/LOAD/RUN); fetch answers exactly 1 cycle after request.
// Load port is valid/ready: LOAD_READY only in LOAD, so the producer stalls once the load ends.
module inst_mem_loader #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    inst_mem_loader_if.slave        bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  load_cnt;
    logic              load_rdy;
    logic              load_done;
    logic              busy;
    logic [DATA_W-1:0] instr;
    logic              fetch_vld;
    logic              fetch_fault;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              load_end;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] word_idx;
    logic              aligned;
    logic              in_range;
    logic [PTR_W-1:0]  rd_idx;

    // A restart in the same cycle as an accepted word redirects that word to index 0.
    always_comb begin
        accept   = load_rdy && bus.LOAD_VALID;
        wr_idx   = bus.LOAD_START ? '0 : ptr;
        load_end = accept && (bus.LOAD_LAST || (wr_idx == PTR_W'(DEPTH - 1)));
        word_idx = bus.Read_address >> BYTE_SH;
        aligned  = (bus.Read_address & ADDR_W'(DATA_W / 8 - 1)) == '0;
        in_range = word_idx < ADDR_W'(DEPTH);
        rd_idx   = word_idx[PTR_W-1:0];
    end

    // Contents survive reset; only writes are blocked while reset is asserted.
    always_ff @(posedge CLK) begin
        if (RESET_N && accept) begin
            mem[wr_idx] <= bus.LOAD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            ptr         <= '0;
            load_cnt    <= '0;
            load_rdy    <= 1'b0;
            load_done   <= 1'b0;
            busy        <= 1'b0;
            instr       <= NOP_WORD;
            fetch_vld   <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            load_done <= 1'b0;

            // Fetch path is decided on the current state, so a fetch coinciding
            // with LOAD_START in RUN is still served from the array.
            if (bus.FETCH_REQ) begin
                fetch_vld <= 1'b1;
                if (state == RUN && aligned && in_range) begin
                    instr       <= mem[rd_idx];
                    fetch_fault <= 1'b0;
                end else begin
                    instr       <= NOP_WORD;
                    fetch_fault <= 1'b1;
                end
            end else begin
                fetch_vld   <= 1'b0;
                fetch_fault <= 1'b0;
            end

            case (state)
                IDLE, RUN: begin
                    if (bus.LOAD_START) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        load_cnt <= '0;
                        load_rdy <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ptr <= wr_idx + PTR_W'(1);
                        if (bus.LOAD_START) begin
                            load_cnt <= CNT_W'(1);
                        end else if (load_cnt != CNT_W'(DEPTH)) begin
                            load_cnt <= load_cnt + CNT_W'(1);
                        end
                        if (load_end) begin
                            state     <= RUN;
                            load_rdy  <= 1'b0;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end else if (bus.LOAD_START) begin
                        ptr      <= '0;
                        load_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    load_rdy <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LOAD_READY  = load_rdy;
    assign bus.LOAD_DONE   = load_done;
    assign bus.LOAD_COUNT  = load_cnt;
    assign bus.BUSY        = busy;
    assign bus.Instruction = instr;
    assign bus.FETCH_VALID = fetch_vld;
    assign bus.FETCH_FAULT = fetch_fault;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: fetch expectations are queued at request time
// and matched by a negedge monitor; load-side status is checked inline.
module tb_inst_mem_loader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    inst_mem_loader_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    inst_mem_loader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] src [70];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Fetch responses must appear exactly on their due cycle, in order.
    always @(negedge CLK) begin
        if (bus.FETCH_VALID) begin
            if (sb.size() == 0) begin
                check("fetch_unexpected", bus.FETCH_VALID, 0);
            end else begin
                e = sb.pop_front();
                check("fetch_cycle", cyc, e.due);
                check("fetch_instr", bus.Instruction, e.instr);
                check("fetch_fault", bus.FETCH_FAULT, e.fault);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("fetch_missing", bus.FETCH_VALID, 1);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_instr, input logic exp_fault);
        bus.FETCH_REQ    = 1'b1;
        bus.Read_address = pc;
        sb.push_back('{exp_instr, exp_fault, cyc + 1});
        tick();
    endtask

    task automatic load_prog(input int n, input bit use_last, input int gap_at, input int exp_cnt);
        bus.FETCH_REQ  = 1'b0;
        bus.LOAD_START = 1'b1;
        tick();
        bus.LOAD_START = 1'b0;
        check("busy_on_start", bus.BUSY, 1);
        check("ready_on_start", bus.LOAD_READY, 1);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                bus.LOAD_VALID = 1'b0;
                tick();
            end
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_DATA  = src[i];
            bus.LOAD_LAST  = use_last && (i == n - 1);
            check("load_ready", bus.LOAD_READY, (i < exp_cnt));
            tick();
            if (i < exp_cnt) model_mem[i] = src[i];
            check("load_done", bus.LOAD_DONE, (i == exp_cnt - 1));
        end
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_LAST  = 1'b0;
        check("load_count", bus.LOAD_COUNT, exp_cnt);
        check("busy_after_load", bus.BUSY, 0);
        check("ready_after_load", bus.LOAD_READY, 0);
    endtask

    initial begin
        bus.LOAD_START   = 1'b0;
        bus.LOAD_VALID   = 1'b0;
        bus.LOAD_DATA    = '0;
        bus.LOAD_LAST    = 1'b0;
        bus.Read_address = '0;
        bus.FETCH_REQ    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count", bus.LOAD_COUNT, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_ready", bus.LOAD_READY, 0);
        check("rst_done", bus.LOAD_DONE, 0);
        check("rst_fvalid", bus.FETCH_VALID, 0);
        check("rst_ffault", bus.FETCH_FAULT, 0);
        check("rst_instr", bus.Instruction, NOP);
        RESET_N = 1'b1;
        tick();

        // Fetch in IDLE faults
        fetch(32'd0, NOP, 1'b1);
        bus.FETCH_REQ = 1'b0;
        tick();

        // Three-word program, idle gap before the second word
        src[0] = 32'h2008_0005;
        src[1] = 32'h2009_0007;
        src[2] = 32'h0109_5020;
        load_prog(3, 1'b1, 1, 3);
        fetch(32'd0, 32'h2008_0005, 1'b0);
        fetch(32'd4, 32'h2009_0007, 1'b0);
        fetch(32'd8, 32'h0109_5020, 1'b0);
        bus.FETCH_REQ = 1'b0;
        tick();
        check("idle_fvalid", bus.FETCH_VALID, 0);
        check("idle_hold_instr", bus.Instruction, 32'h0109_5020);
        fetch(32'd2, NOP, 1'b1);
        fetch(32'd256, NOP, 1'b1);
        fetch(32'h0001_0000, NOP, 1'b1);
        bus.FETCH_REQ = 1'b0;
        tick();

        // Overfill: 70 words offered, 64 accepted
        for (int i = 0; i < 70; i++) src[i] = 32'hA000_0000 + i;
        load_prog(70, 1'b0, -1, 64);
        fetch(32'd252, 32'hA000_003F, 1'b0);
        fetch(32'd0, 32'hA000_0000, 1'b0);
        bus.FETCH_REQ = 1'b0;
        tick();

        // Reset after 2 of 5 words
        for (int i = 0; i < 5; i++) src[i] = 32'hB000_0000 + i;
        bus.LOAD_START = 1'b1;
        tick();
        bus.LOAD_START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_DATA  = src[i];
            tick();
            model_mem[i] = src[i];
        end
        bus.LOAD_VALID = 1'b0;
        check("partial_count", bus.LOAD_COUNT, 2);
        fetch(32'd0, NOP, 1'b1);
        bus.FETCH_REQ  = 1'b0;
        RESET_N        = 1'b0;
        bus.LOAD_VALID = 1'b1;
        bus.LOAD_DATA  = src[2];
        tick();
        RESET_N        = 1'b1;
        bus.LOAD_VALID = 1'b0;
        check("abort_count", bus.LOAD_COUNT, 0);
        check("abort_busy", bus.BUSY, 0);
        check("abort_ready", bus.LOAD_READY, 0);
        check("abort_done", bus.LOAD_DONE, 0);
        check("abort_instr", bus.Instruction, NOP);
        fetch(32'd4, NOP, 1'b1);
        bus.FETCH_REQ = 1'b0;
        for (int i = 0; i < 5; i++) src[i] = 32'hC000_0000 + i;
        load_prog(5, 1'b1, -1, 5);
        fetch(32'd4, 32'hC000_0001, 1'b0);
        bus.FETCH_REQ = 1'b0;
        tick();

        // Reprogram: fetch together with LOAD_START still reads the old word
        bus.LOAD_START = 1'b1;
        fetch(32'd0, model_mem[0], 1'b0);
        bus.LOAD_START = 1'b0;
        bus.FETCH_REQ  = 1'b0;
        check("reprog_busy", bus.BUSY, 1);
        fetch(32'd0, NOP, 1'b1);
        bus.FETCH_REQ = 1'b0;
        src[0] = 32'hD000_0000;
        load_prog(1, 1'b1, -1, 1);
        fetch(32'd0, 32'hD000_0000, 1'b0);
        fetch(32'd4, 32'hC000_0001, 1'b0);
        bus.FETCH_REQ = 1'b0;

        tick();
        tick();
        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
